wshb_ram_slave: RTL and testbench
=================================

# wshb_ram_slave

Wishbone B4 pipelined-free responder backed by an on-chip RAM, the target-side counterpart of the frame-buffer master port driven by the bus arbiter. Serves classic single cycles and registered-feedback incrementing bursts (linear and wrap-4/8/16), so the test-pattern generator and VGA reader can run end-to-end in simulation and on-chip without external SDRAM. Sits directly on the arbiter's downstream master port.

## Interface
- `DEPTH`, 4096: RAM size in 32-bit words; power of two.
- `INIT_FILE`, "": optional `$readmemh` image; empty means contents undefined after power-up.
- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cyc` in 1: bus cycle valid.
- `stb` in 1: beat strobe.
- `we` in 1: 1 = write.
- `adr` in 32: byte address; word index = `adr[$clog2(DEPTH)+1:2]`, upper bits ignored (aliasing).
- `sel` in 4: byte enables for writes, `sel[i]` covers `dat_ms[8i+7:8i]`.
- `cti` in 3: cycle type.
- `bte` in 2: burst type.
- `dat_ms` in 32: write data.
- `dat_sm` out 32: read data, valid only while `ack`.
- `ack` out 1: beat acknowledge.
- `err` out 1: error termination.

## Operation
- States: IDLE, CLASSIC, BURST, ERR.
- IDLE: on `cyc&stb` sampled at an edge: `cti`∈{000,001,111} -> CLASSIC; `cti`=010 -> BURST; `cti`∈{011..110} -> ERR. Beat pointer `ptr` loaded with word index of `adr`.
- CLASSIC: `ack`=1 for exactly one cycle (gated by `cyc&stb`), then IDLE. Write performed at end of the acked cycle with `ptr`, `sel`, `dat_ms`; read data `mem[ptr]`.
- BURST: `ack = cyc & stb`. Each acked cycle: write (if `we`) at `ptr`, then `ptr <= next(ptr,bte)`; RAM read port prefetches `mem[next]` so read data is ready the following cycle. `adr` is ignored after the first beat.
- `stb`=0 in BURST (master wait): no ack, `ptr` and prefetched data hold.
- Acked beat with `cti`=111 -> IDLE (no further ack).
- ERR: `err`=1 for one cycle (gated by `cyc&stb`), no memory write, then IDLE. `ack` and `err` never both high.
- `cyc`=0 in any state -> IDLE at the next edge; outputs already low because gated by `cyc`.
- `next`: `bte`=00 `ptr+1` mod DEPTH; 01/10/11 wrap within 4/8/16-word aligned block: `{ptr[hi:n], ptr[n-1:0]+1}`, n=2/3/4.
- Reset (asynchronous, mid-burst included): state IDLE, `ack`=0, `err`=0, `dat_sm`=0, `ptr`=0 immediately; RAM contents preserved.

## Timing
- Request first seen in cycle k (sampled at edge ending k) -> `ack`/`err` in cycle k+1.
- Classic: one ack per two cycles minimum; new classic request in k+2 acked in k+3.
- Burst: beats acked back-to-back from k+1 while `stb` high; one beat per cycle; read beat j data equals `mem[ptr_j]` including after master wait states.
- Write takes effect at the edge ending its acked cycle; a read of the same word in the immediately following beat returns the new data (write-first bypass).
- `dat_sm` is don't-care outside `ack`, 0 after reset.

## Structure
- Package `wshb_pkg`: `cti_t` enum (CLASSIC=000, CONST=001, INCR=010, EOB=111), `bte_t` enum (LINEAR, WRAP4, WRAP8, WRAP16), `state_t` enum for this block.
- Sub-module `wshb_burst_addr`: combinational `next(ptr,bte)` with parameter `AW`; reused by any future burst master.
- RAM inferred in-module as byte-enabled single-port synchronous array.

## Test plan
- Classic write 0xDEADBEEF to 0x10, `sel`=1111, then classic read 0x10 -> ack one cycle after each request, read `dat_sm`=0xDEADBEEF.
- Byte write `sel`=0010, data 0x0000AB00 to 0x10 -> read returns 0xDEADABEF.
- INCR linear read burst 4 beats from 0x00 preloaded 1,2,3,4 (`cti`=111 on beat 4) -> `ack` high 4 consecutive cycles, data 1,2,3,4, ack low after.
- WRAP4 burst starting at 0x08 (word 2) -> pointer sequence words 2,3,0,1.
- Master drops `stb` for 2 cycles after beat 2 of an 8-beat burst -> no ack during gap, beat 3 data correct on resume.
- `cti`=101 -> `err` one cycle, no ack, memory unchanged; assert `rst_n`=0 mid-burst -> `ack` low immediately, prior writes retained.

Source files
------------

// File: rtl/wshb_pkg.sv
// Shared Wishbone B4 cycle-type, burst-type and responder-state definitions.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package wshb_pkg;

  // Cycle type identifiers carried on cti.
  typedef enum logic [2:0] {
    CTI_CLASSIC = 3'b000,
    CTI_CONST   = 3'b001,
    CTI_INCR    = 3'b010,
    CTI_EOB     = 3'b111
  } cti_t;

  // Burst type identifiers carried on bte.
  typedef enum logic [1:0] {
    BTE_LINEAR = 2'b00,
    BTE_WRAP4  = 2'b01,
    BTE_WRAP8  = 2'b10,
    BTE_WRAP16 = 2'b11
  } bte_t;

  // RAM responder protocol states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_CLASSIC = 2'b01,
    ST_BURST   = 2'b10,
    ST_ERR     = 2'b11
  } state_t;

  localparam int DATA_W = 32;
  localparam int SEL_W  = DATA_W / 8;

  // State entered from IDLE for a newly strobed request with the given cti.
  function automatic state_t decode_cti(input logic [2:0] cti);
    state_t s;
    case (cti)
      CTI_CLASSIC, CTI_CONST, CTI_EOB: s = ST_CLASSIC;
      CTI_INCR:                        s = ST_BURST;
      default:                         s = ST_ERR;
    endcase
    return s;
  endfunction

  // Overlay the byte lanes enabled in sel from new_word onto old_word.
  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_word,
                                                    input logic [DATA_W-1:0] new_word,
                                                    input logic [SEL_W-1:0]  sel);
    logic [DATA_W-1:0] r;
    r = old_word;
    for (int i = 0; i < SEL_W; i++) begin
      if (sel[i]) r[8*i +: 8] = new_word[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/wshb_burst_addr.sv
// Next word pointer of a Wishbone incrementing burst (linear or wrap-4/8/16).
// Latency: purely combinational.
// Backpressure: none; the caller decides when to advance.
module wshb_burst_addr
  import wshb_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic [AW-1:0] ptr,
  input  bte_t          bte,
  output logic [AW-1:0] nxt
);

  logic [AW-1:0] inc;
  logic [AW-1:0] wrap_mask;

  assign inc = ptr + AW'(1);

  // Bits covered by the mask come from the increment, the rest stay put,
  // so a wrap burst never leaves its aligned 4/8/16-word block.
  always_comb begin
    wrap_mask = '1;
    case (bte)
      BTE_LINEAR: wrap_mask = '1;
      BTE_WRAP4:  wrap_mask = AW'(3);
      BTE_WRAP8:  wrap_mask = AW'(7);
      BTE_WRAP16: wrap_mask = AW'(15);
      default:    wrap_mask = '1;
    endcase
  end

  assign nxt = (ptr & ~wrap_mask) | (inc & wrap_mask);

endmodule

// File: rtl/wshb_ram_slave.sv
// Wishbone B4 responder backed by a byte-enabled on-chip RAM (classic + incrementing bursts).
// Latency: ack/err one cycle after a request is first sampled; bursts then stream one beat per cycle.
// Backpressure: stb low stalls a burst with pointer and prefetched read data held; cyc low aborts to IDLE.
module wshb_ram_slave
  import wshb_pkg::*;
#(
  parameter int DEPTH     = 4096,
  parameter     INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cyc,
  input  logic        stb,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [3:0]  sel,
  input  logic [2:0]  cti,
  input  logic [1:0]  bte,
  input  logic [31:0] dat_ms,
  output logic [31:0] dat_sm,
  output logic        ack,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);
  localparam bit INIT_PRESENT = (INIT_FILE != "");

  state_t        state;
  logic [AW-1:0] ptr;
  logic [AW-1:0] ptr_nxt;
  logic [AW-1:0] ptr_inc;
  logic [AW-1:0] adr_word;
  logic          req;
  logic          beat;
  logic          wr_en;
  logic [31:0]   rd_q;
  logic [31:0]   mem [DEPTH];

  // Address bits outside the word index are ignored, so the RAM aliases.
  logic unused_bits;
  assign unused_bits = ^{adr[31:AW+2], adr[1:0], INIT_PRESENT};

  assign req      = cyc & stb;
  assign adr_word = adr[AW+1:2];

  // Responses are gated by the live strobe so dropping cyc/stb silences them at once.
  assign beat   = req & ((state == ST_CLASSIC) | (state == ST_BURST));
  assign ack    = beat;
  assign err    = req & (state == ST_ERR);
  assign wr_en  = beat & we;
  assign dat_sm = rd_q;

  wshb_burst_addr #(
    .AW (AW)
  ) u_burst_addr (
    .ptr (ptr),
    .bte (bte_t'(bte)),
    .nxt (ptr_inc)
  );

  // Pointer for the coming cycle: load from adr on a new request, advance after each burst beat.
  always_comb begin
    ptr_nxt = ptr;
    case (state)
      ST_IDLE:  if (req) ptr_nxt = adr_word;
      ST_BURST: if (req) ptr_nxt = ptr_inc;
      default:  ptr_nxt = ptr;
    endcase
  end

  // Protocol FSM: classic and error responses last one strobed cycle; bursts end on an acked EOB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else if (!cyc) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:            if (stb) state <= decode_cti(cti);
        ST_CLASSIC, ST_ERR: if (stb) state <= ST_IDLE;
        ST_BURST:           if (stb && (cti == CTI_EOB)) state <= ST_IDLE;
        default:            state <= ST_IDLE;
      endcase
    end
  end

  // Beat pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= '0;
    else        ptr <= ptr_nxt;
  end

  // Byte-enabled write at the edge that ends an acked write beat; contents survive reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_en && sel[i]) mem[ptr][8*i +: 8] <= dat_ms[8*i +: 8];
    end
  end

  // Read register follows the next pointer, so data for the coming beat is ready when it is
  // acked; a same-word write in this edge is forwarded (write-first).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
    end else if (wr_en && (ptr == ptr_nxt)) begin
      rd_q <= merge_bytes(mem[ptr_nxt], dat_ms, sel);
    end else begin
      rd_q <= mem[ptr_nxt];
    end
  end

  // A beat is either acknowledged or errored, never both.
  ack_err_excl: assert property (@(posedge clk) disable iff (!rst_n) !(ack && err));

endmodule

// File: tb/tb_wshb_ram_slave.sv
module tb_wshb_ram_slave;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic [31:0] adr = '0;
  logic [3:0]  sel = '0;
  logic [2:0]  cti = '0;
  logic [1:0]  bte = '0;
  logic [31:0] dat_ms = '0;
  logic [31:0] dat_sm;
  logic        ack;
  logic        err;

  int total = 0;
  int passed = 0;

  // Reference memory: word contents and whether every byte has been written.
  logic [31:0] model [DEPTH];
  bit          known [DEPTH];

  // Per-beat burst scratch: write data, captured read data, cycle of ack.
  logic [31:0] bw [16];
  logic [31:0] br [16];
  int          bc [16];

  wshb_ram_slave #(
    .DEPTH     (DEPTH),
    .INIT_FILE ("")
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .cyc    (cyc),
    .stb    (stb),
    .we     (we),
    .adr    (adr),
    .sel    (sel),
    .cti    (cti),
    .bte    (bte),
    .dat_ms (dat_ms),
    .dat_sm (dat_sm),
    .ack    (ack),
    .err    (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int word_of(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  function automatic int model_next(input int p, input int b);
    int blk;
    if (b == 0) return (p + 1) % DEPTH;
    blk = 2 << b;
    return (p / blk) * blk + ((p % blk) + 1) % blk;
  endfunction

  function automatic void model_write(input int p, input logic [31:0] d, input logic [3:0] s);
    for (int i = 0; i < 4; i++) if (s[i]) model[p][8*i +: 8] = d[8*i +: 8];
    if (s == 4'hF) known[p] = 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One classic transaction; returns cycles from request to response, data and response kind.
  task automatic classic_op(input logic w, input logic [31:0] a, input logic [3:0] s,
                            input logic [31:0] d, input logic [2:0] c,
                            output int lat, output logic [31:0] rdat,
                            output logic saw_err, output int nack);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_ms = d; cti = c; bte = 2'b00;
    lat = -1; rdat = '0; saw_err = 1'b0; nack = 0;
    for (int i = 0; i < 8 && lat < 0; i++) begin
      @(negedge clk);
      if (ack) nack++;
      if (ack || err) begin
        lat = i; rdat = dat_sm; saw_err = err;
      end
      tick();
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  // One incrementing burst of n beats, optional stb gap of gap_len cycles once gap_at beats are done.
  task automatic burst_op(input logic w, input logic [31:0] a, input logic [1:0] b,
                          input int n, input int gap_at, input int gap_len,
                          output int nbeats, output int stall_acks, output int post_ack);
    int gaps;
    int cycle;
    nbeats = 0; stall_acks = 0; post_ack = 0; gaps = 0; cycle = 0;
    cyc = 1'b1; we = w; adr = a; bte = b; sel = 4'hF;
    while (nbeats < n && cycle < 64) begin
      stb = !(nbeats == gap_at && gaps < gap_len && cycle > 0);
      cti = (nbeats == n - 1) ? 3'b111 : 3'b010;
      dat_ms = bw[nbeats];
      @(negedge clk);
      if (ack) begin
        if (!stb) stall_acks++;
        br[nbeats] = dat_sm; bc[nbeats] = cycle; nbeats++;
      end
      if (!stb) gaps++;
      tick();
      cycle++;
    end
    stb = 1'b1; cti = 3'b111;
    @(negedge clk);
    post_ack = int'(ack);
    tick();
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    @(negedge clk);
    total++; if (ack !== 1'b0) $display("FAIL reset_ack: got %b want 0", ack); else passed++;
    total++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else passed++;
    total++; if (dat_sm !== 32'h0) $display("FAIL reset_dat: got %h want 0", dat_sm); else passed++;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_classic();
    int lat, na; logic [31:0] rd; logic e;
    classic_op(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 3'b000, lat, rd, e, na);
    model_write(word_of(32'h10), 32'hDEADBEEF, 4'hF);
    total++; if (lat !== 1) $display("FAIL classic_wr_lat: got %0d want 1", lat); else passed++;
    total++; if (na !== 1) $display("FAIL classic_wr_acks: got %0d want 1", na); else passed++;
    classic_op(1'b0, 32'h10, 4'hF, 32'h0, 3'b000, lat, rd, e, na);
    total++; if (lat !== 1) $display("FAIL classic_rd_lat: got %0d want 1", lat); else passed++;
    total++; if (rd !== 32'hDEADBEEF) $display("FAIL classic_rd_dat: got %h want deadbeef", rd); else passed++;
    total++; if (e !== 1'b0) $display("FAIL classic_rd_err: got %b want 0", e); else passed++;
  endtask

  task automatic test_byte_write();
    int lat, na; logic [31:0] rd; logic e;
    classic_op(1'b1, 32'h10, 4'b0010, 32'h0000AB00, 3'b111, lat, rd, e, na);
    model_write(word_of(32'h10), 32'h0000AB00, 4'b0010);
    total++; if (lat !== 1) $display("FAIL byte_wr_lat: got %0d want 1", lat); else passed++;
    classic_op(1'b0, 32'h10, 4'hF, 32'h0, 3'b001, lat, rd, e, na);
    total++; if (rd !== 32'hDEADABEF) $display("FAIL byte_rd_dat: got %h want deadabef", rd); else passed++;
  endtask

  task automatic test_incr_burst();
    int lat, na, nb, sa, pa; logic [31:0] rd; logic e;
    for (int j = 0; j < 4; j++) begin
      classic_op(1'b1, 32'(4 * j), 4'hF, 32'(j + 1), 3'b000, lat, rd, e, na);
      model_write(j, 32'(j + 1), 4'hF);
    end
    burst_op(1'b0, 32'h0, 2'b00, 4, -1, 0, nb, sa, pa);
    total++; if (nb !== 4) $display("FAIL incr_beats: got %0d want 4", nb); else passed++;
    for (int j = 0; j < 4; j++) begin
      total++; if (bc[j] !== 1 + j) $display("FAIL incr_cycle[%0d]: got %0d want %0d", j, bc[j], 1 + j); else passed++;
      total++; if (br[j] !== 32'(j + 1)) $display("FAIL incr_dat[%0d]: got %h want %h", j, br[j], j + 1); else passed++;
    end
    total++; if (pa !== 0) $display("FAIL incr_ack_after: got %0d want 0", pa); else passed++;
  endtask

  task automatic test_wrap4();
    int nb, sa, pa;
    int seq [4] = '{2, 3, 0, 1};
    burst_op(1'b0, 32'h08, 2'b01, 4, -1, 0, nb, sa, pa);
    total++; if (nb !== 4) $display("FAIL wrap4_beats: got %0d want 4", nb); else passed++;
    for (int j = 0; j < 4; j++) begin
      total++; if (br[j] !== 32'(seq[j] + 1)) $display("FAIL wrap4_dat[%0d]: got %h want %h", j, br[j], seq[j] + 1); else passed++;
    end
  endtask

  task automatic test_wait_states();
    int nb, sa, pa, exp_c;
    logic [31:0] wd [8];
    for (int j = 0; j < 8; j++) begin
      wd[j] = $urandom; bw[j] = wd[j];
      model_write(16 + j, wd[j], 4'hF);
    end
    burst_op(1'b1, 32'h40, 2'b00, 8, 5, 1, nb, sa, pa);
    total++; if (nb !== 8) $display("FAIL wait_wr_beats: got %0d want 8", nb); else passed++;
    burst_op(1'b0, 32'h40, 2'b00, 8, 2, 2, nb, sa, pa);
    total++; if (nb !== 8) $display("FAIL wait_rd_beats: got %0d want 8", nb); else passed++;
    total++; if (sa !== 0) $display("FAIL wait_gap_acks: got %0d want 0", sa); else passed++;
    for (int j = 0; j < 8; j++) begin
      exp_c = 1 + j + ((j >= 2) ? 2 : 0);
      total++; if (bc[j] !== exp_c) $display("FAIL wait_cycle[%0d]: got %0d want %0d", j, bc[j], exp_c); else passed++;
      total++; if (br[j] !== wd[j]) $display("FAIL wait_dat[%0d]: got %h want %h", j, br[j], wd[j]); else passed++;
    end
  endtask

  task automatic test_err();
    int lat, na; logic [31:0] rd; logic e;
    classic_op(1'b1, 32'h10, 4'hF, 32'h12345678, 3'b101, lat, rd, e, na);
    total++; if (e !== 1'b1) $display("FAIL err_seen: got %b want 1", e); else passed++;
    total++; if (lat !== 1) $display("FAIL err_lat: got %0d want 1", lat); else passed++;
    total++; if (na !== 0) $display("FAIL err_no_ack: got %0d want 0", na); else passed++;
    classic_op(1'b0, 32'h10, 4'hF, 32'h0, 3'b000, lat, rd, e, na);
    total++; if (rd !== model[4]) $display("FAIL err_mem_kept: got %h want %h", rd, model[4]); else passed++;
  endtask

  task automatic test_reset_mid_burst();
    int lat, na, n, cycles; logic [31:0] rd; logic e;
    logic [31:0] wd [4];
    classic_op(1'b1, 32'h8C, 4'hF, 32'hCAFEF00D, 3'b000, lat, rd, e, na);
    model_write(32'h23, 32'hCAFEF00D, 4'hF);
    for (int j = 0; j < 4; j++) wd[j] = $urandom;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h80; bte = 2'b00; sel = 4'hF; cti = 3'b010;
    n = 0; cycles = 0;
    while (n < 3 && cycles < 16) begin
      dat_ms = wd[n];
      @(negedge clk);
      if (ack) n++;
      tick();
      cycles++;
    end
    dat_ms = wd[3];
    @(negedge clk);
    total++; if (ack !== 1'b1) $display("FAIL rstmid_pre_ack: got %b want 1", ack); else passed++;
    rst_n = 1'b0;
    #1;
    total++; if (ack !== 1'b0) $display("FAIL rstmid_ack: got %b want 0", ack); else passed++;
    total++; if (dat_sm !== 32'h0) $display("FAIL rstmid_dat: got %h want 0", dat_sm); else passed++;
    tick();
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    rst_n = 1'b1;
    tick();
    for (int j = 0; j < 3; j++) model_write(32 + j, wd[j], 4'hF);
    for (int j = 0; j < 4; j++) begin
      classic_op(1'b0, 32'(32'h80 + 4 * j), 4'hF, 32'h0, 3'b000, lat, rd, e, na);
      total++; if (rd !== model[32 + j]) $display("FAIL rstmid_kept[%0d]: got %h want %h", j, rd, model[32 + j]); else passed++;
    end
  endtask

  task automatic test_random();
    int lat, na, nb, sa, pa, p, n, b, gap_at, gap_len, exp_c;
    logic [31:0] a, d, rd; logic [3:0] s; logic [2:0] c; logic w, e;
    logic [31:0] exp_d [16]; bit exp_k [16];
    logic [2:0] ctis [3] = '{3'b000, 3'b001, 3'b111};
    for (int it = 0; it < 40; it++) begin
      w = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) begin
        p = $urandom_range(0, 63);
        a = (32'(p) << 2) | (32'($urandom_range(0, 7)) << 10) | 32'($urandom_range(0, 3));
        s = known[p] ? 4'($urandom_range(1, 15)) : 4'hF;
        d = $urandom;
        c = ctis[$urandom_range(0, 2)];
        classic_op(w, a, s, d, c, lat, rd, e, na);
        total++; if (lat !== 1) $display("FAIL rnd_classic_lat[%0d]: got %0d want 1", it, lat); else passed++;
        if (w) model_write(p, d, s);
        else if (known[p]) begin
          total++; if (rd !== model[p]) $display("FAIL rnd_classic_dat[%0d]: got %h want %h", it, rd, model[p]); else passed++;
        end
      end else begin
        b = $urandom_range(0, 3);
        n = $urandom_range(1, 8);
        gap_at = ($urandom_range(0, 1) == 1) ? $urandom_range(0, n - 1) : -1;
        gap_len = $urandom_range(1, 3);
        p = $urandom_range(0, 63);
        a = (32'(p) << 2) | (32'($urandom_range(0, 7)) << 10);
        for (int j = 0; j < n; j++) begin
          bw[j] = $urandom;
          exp_d[j] = model[p]; exp_k[j] = known[p];
          if (w) model_write(p, bw[j], 4'hF);
          p = model_next(p, b);
        end
        burst_op(w, a, 2'(b), n, gap_at, gap_len, nb, sa, pa);
        total++; if (nb !== n) $display("FAIL rnd_burst_beats[%0d]: got %0d want %0d", it, nb, n); else passed++;
        total++; if (pa !== 0) $display("FAIL rnd_burst_ack_after[%0d]: got %0d want 0", it, pa); else passed++;
        for (int j = 0; j < nb; j++) begin
          exp_c = 1 + j + ((gap_at >= 0 && j >= gap_at) ? gap_len : 0);
          total++; if (bc[j] !== exp_c) $display("FAIL rnd_burst_cycle[%0d.%0d]: got %0d want %0d", it, j, bc[j], exp_c); else passed++;
          if (!w && exp_k[j]) begin
            total++; if (br[j] !== exp_d[j]) $display("FAIL rnd_burst_dat[%0d.%0d]: got %h want %h", it, j, br[j], exp_d[j]); else passed++;
          end
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      model[i] = '0; known[i] = 1'b0;
    end
    test_reset();
    test_classic();
    test_byte_write();
    test_incr_burst();
    test_wrap4();
    test_wait_states();
    test_err();
    test_reset_mid_burst();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
